piso_tx: RTL and testbench

- Serial transmitter at the output end of the 4x4 multiplier datapath; the inverse of the SIPO receive stage.
- When the control FSM asserts piso_enable, the block captures the parallel product and shifts it out as a framed serial stream on one line.
- Frame format: start bit, data bits, optional parity bit, stop bit.
- Pulses piso_done when the frame completes.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/piso_bit_timer.sv | 28 ++
 rtl/piso_tx.sv | 144 ++++++++++++++
 tb/tb_piso_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and piso_tx state encodings for the 4x4 multiplier datapath
package mult_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic IDLE_LINE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5,
    ST_HOLD   = 3'd6
  } piso_state_t;

endpackage

// File: rtl/piso_bit_timer.sv
// rtl/piso_bit_timer.sv - bit-period timer; bit_tick marks the last cycle of each serial bit
module piso_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = enable && (cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - framed serial transmitter for the multiplier product
// Optional even-parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int DATA_WIDTH   = mult_pkg::DATA_WIDTH,
  parameter int CLKS_PER_BIT = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  piso_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  piso_done
);

  import mult_pkg::*;

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  piso_state_t           state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [BW-1:0]         bit_cnt;
  logic                  out_bit;
  logic                  timer_en;
  logic                  bit_tick;
`ifdef PISO_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // The bit on the line always comes from the outgoing end of the shift register.
  always_comb begin
    out_bit    = 1'b0;
    shreg_next = shreg;
    timer_en   = 1'b0;
    if (LSB_FIRST != 0) begin
      out_bit    = shreg[0];
      shreg_next = {1'b0, shreg[DATA_WIDTH-1:1]};
    end else begin
      out_bit    = shreg[DATA_WIDTH-1];
      shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
    end
    timer_en = (state == ST_START) || (state == ST_DATA) ||
               (state == ST_PARITY) || (state == ST_STOP);
  end

  piso_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (timer_en),
    .clear    (!timer_en),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      serial_out <= IDLE_LINE;
      busy       <= 1'b0;
      piso_done  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      piso_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          serial_out <= IDLE_LINE;
          busy       <= 1'b0;
          if (piso_enable) begin
            shreg      <= data_in;
            bit_cnt    <= '0;
`ifdef PISO_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
            serial_out <= START_BIT;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            serial_out <= out_bit;
            shreg      <= shreg_next;
            bit_cnt    <= '0;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
              serial_out <= parity_bit;
              state      <= ST_PARITY;
`else
              serial_out <= STOP_BIT;
              state      <= ST_STOP;
`endif
            end else begin
              serial_out <= out_bit;
              shreg      <= shreg_next;
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef PISO_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            serial_out <= STOP_BIT;
            state      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            serial_out <= IDLE_LINE;
            busy       <= 1'b0;
            piso_done  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Enable already low means the request is over: skip HOLD entirely.
          state <= piso_enable ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (!piso_enable) state <= ST_IDLE;
        end
        default: begin
          serial_out <= IDLE_LINE;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx (LSB-first, MSB-first and slow-bit instances)
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L = 10 + PB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       piso_enable = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic lsb_out, lsb_busy, lsb_done;
  logic msb_out, msb_busy, msb_done;
  logic slw_out, slw_busy, slw_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .piso_enable(piso_enable), .data_in(data_in),
    .serial_out(lsb_out), .busy(lsb_busy), .piso_done(lsb_done));

  piso_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .piso_enable(piso_enable), .data_in(data_in),
    .serial_out(msb_out), .busy(msb_busy), .piso_done(msb_done));

  piso_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) u_slw (
    .clk(clk), .reset(reset), .piso_enable(piso_enable), .data_in(data_in),
    .serial_out(slw_out), .busy(slw_busy), .piso_done(slw_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected line level k bit periods after the capture edge (CLKS_PER_BIT units).
  function automatic logic fbit(input logic [7:0] d, input bit lsb, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return lsb ? d[k-1] : d[8-k];
    if (PB == 1 && k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [7:0] d);
    data_in = d;
    piso_enable = 1'b1;
    tick();
    piso_enable = 1'b0;
    data_in = ~d;
    for (int k = 0; k <= L + 1; k++) begin
      if (k < L) begin
        chk("lsb_line", lsb_out, fbit(d, 1'b1, k));
        chk("msb_line", msb_out, fbit(d, 1'b0, k));
        chk("lsb_busy", lsb_busy, 1);
        chk("msb_busy", msb_busy, 1);
        chk("lsb_done_early", lsb_done, 0);
      end else if (k == L) begin
        chk("lsb_done", lsb_done, 1);
        chk("msb_done", msb_done, 1);
        chk("lsb_busy_done", lsb_busy, 0);
        chk("lsb_line_done", lsb_out, 1);
      end else begin
        chk("lsb_done_pulse", lsb_done, 0);
        chk("lsb_busy_after", lsb_busy, 0);
      end
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int dcnt_l;
    int dcnt_s;

    // Reset state
    tick();
    tick();
    chk("rst_lsb_line", lsb_out, 1);
    chk("rst_lsb_busy", lsb_busy, 0);
    chk("rst_lsb_done", lsb_done, 0);
    chk("rst_msb_line", msb_out, 1);
    chk("rst_slw_line", slw_out, 1);
    chk("rst_slw_busy", slw_busy, 0);
    reset = 1'b0;
    tick();

    // Basic frames: 0xA5, 0x07 (parity 1), 0xA5 again is covered later
    run_frame(8'hA5);
    run_frame(8'h07);
    idle(60);

    // Slow bit rate: 4 clocks per bit, data 0xFF
    data_in = 8'hFF;
    piso_enable = 1'b1;
    tick();
    piso_enable = 1'b0;
    for (int k = 0; k <= 4 * L + 1; k++) begin
      if (k < 4 * L) begin
        chk("slw_line", slw_out, fbit(8'hFF, 1'b1, k / 4));
        chk("slw_busy", slw_busy, 1);
        chk("slw_done_early", slw_done, 0);
      end else if (k == 4 * L) begin
        chk("slw_done", slw_done, 1);
        chk("slw_busy_done", slw_busy, 0);
      end else begin
        chk("slw_done_pulse", slw_done, 0);
      end
      tick();
    end
    idle(5);

    // Enable held high: exactly one frame each
    data_in = 8'h3C;
    piso_enable = 1'b1;
    dcnt_l = 0;
    dcnt_s = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (lsb_done) dcnt_l++;
      if (slw_done) dcnt_s++;
    end
    chk("held_lsb_done_count", dcnt_l, 1);
    chk("held_slw_done_count", dcnt_s, 1);
    chk("held_lsb_busy", lsb_busy, 0);
    chk("held_lsb_line", lsb_out, 1);
    piso_enable = 1'b0;
    tick();
    run_frame(8'h3C);
    idle(60);

    // Reset during data bit 3 of 0xA5
    data_in = 8'hA5;
    piso_enable = 1'b1;
    tick();
    piso_enable = 1'b0;
    idle(4);
    chk("mid_bit3_line", lsb_out, 0);
    chk("mid_bit3_busy", lsb_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_line", lsb_out, 1);
    chk("abort_busy", lsb_busy, 0);
    chk("abort_done", lsb_done, 0);
    dcnt_l = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (lsb_done) dcnt_l++;
    end
    chk("abort_no_done", dcnt_l, 0);
    run_frame(8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
